// File: rtl/serdes_pkg.sv
// Shared types and constants for the serializer front-end arbiter.
package serdes_pkg;

    localparam int unsigned WORD_W         = 64;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned BYTES_PER_WORD = WORD_W / BYTE_W;
    localparam int unsigned CNT_W          = 16;

    // Scheduler FSM encoding; kept as plain constants for legacy tools.
    typedef logic [1:0] state_t;
    localparam state_t StIdle    = 2'd0;
    localparam state_t StWaitEnd = 2'd1;
    localparam state_t StGap     = 2'd2;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/serializer_arbiter_if.sv
// Bundle of source handshake, serializer load and status signals around the arbiter.
interface serializer_arbiter_if #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned SRC_W   = $clog2(NUM_SRC)
) ();

    logic                                         en;
    logic [NUM_SRC-1:0]                           src_valid;
    logic [NUM_SRC-1:0][serdes_pkg::WORD_W-1:0]   src_data;
    logic [NUM_SRC-1:0]                           src_ack;
    logic                                         ser_strobe_in;
    logic [serdes_pkg::WORD_W-1:0]                ser_input_data;
    logic                                         ser_data_end;
    logic                                         busy;
    logic [SRC_W-1:0]                             cur_src;
    logic                                         done;
    logic                                         err_timeout;
    logic [serdes_pkg::CNT_W-1:0]                 word_cnt;

    // Arbiter side.
    modport master (
        input  en, src_valid, src_data, ser_data_end,
        output src_ack, ser_strobe_in, ser_input_data, busy, cur_src, done, err_timeout,
               word_cnt
    );

    // Environment side: sources, serializer and status consumers.
    modport slave (
        output en, src_valid, src_data, ser_data_end,
        input  src_ack, ser_strobe_in, ser_input_data, busy, cur_src, done, err_timeout,
               word_cnt
    );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_picker #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned SRC_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SRC_W-1:0]   ptr,
    output logic [SRC_W-1:0]   gnt_idx,
    output logic               gnt_any
);

    logic [SRC_W-1:0] cand;

    // Walk candidates in priority order starting at ptr; the first hit wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            cand = SRC_W'((32'(ptr) + k) % NUM_SRC);
            if (!gnt_any && req[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

endmodule

// File: rtl/serializer_arbiter.sv
// Round-robin loader sharing one 64-to-8 serializer between NUM_SRC word producers.
module serializer_arbiter
    import serdes_pkg::*;
#(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned TIMEOUT = 32,
    parameter int unsigned SRC_W   = $clog2(NUM_SRC)
) (
    input logic            clk,
    input logic            reset_n,
    serializer_arbiter_if.master bus
);

    localparam int unsigned        TimerW    = $clog2(TIMEOUT + 1);
    localparam logic [TimerW-1:0]  TimerLast = TimerW'(TIMEOUT - 1);
    localparam logic [SRC_W-1:0]   LastSrc   = SRC_W'(NUM_SRC - 1);

    state_t              state_q, state_d;
    logic [SRC_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [SRC_W-1:0]    cur_src_q, cur_src_d;
    logic [TimerW-1:0]   timer_q, timer_d;
    logic [WORD_W-1:0]   data_q, data_d;
    logic                strobe_q, strobe_d;
    logic [NUM_SRC-1:0]  ack_q, ack_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [SRC_W-1:0]    gnt_idx;
    logic                gnt_any;
    logic [SRC_W-1:0]    next_ptr;

    rr_picker #(
        .NUM_SRC (NUM_SRC),
        .SRC_W   (SRC_W)
    ) u_picker (
        .req     (bus.src_valid),
        .ptr     (rr_ptr_q),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // Fairness: after any burst ends, priority moves to the source after the one served.
    assign next_ptr = (cur_src_q == LastSrc) ? '0 : cur_src_q + SRC_W'(1);

    // Next-state logic: grant in idle, watch for burst end or watchdog, then one gap cycle.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        cur_src_d = cur_src_q;
        timer_d   = timer_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        strobe_d  = 1'b0;
        ack_d     = '0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.en && gnt_any) begin
                    data_d         = bus.src_data[gnt_idx];
                    strobe_d       = 1'b1;
                    ack_d[gnt_idx] = 1'b1;
                    cur_src_d      = gnt_idx;
                    timer_d        = '0;
                    state_d        = StWaitEnd;
                end
            end
            StWaitEnd: begin
                timer_d = timer_q + 1'b1;
                // Burst end takes priority over a coincident watchdog expiry.
                if (bus.ser_data_end) begin
                    done_d   = 1'b1;
                    cnt_d    = sat_inc(cnt_q);
                    rr_ptr_d = next_ptr;
                    state_d  = StGap;
                end else if (timer_q == TimerLast) begin
                    err_d    = 1'b1;
                    rr_ptr_d = next_ptr;
                    state_d  = StGap;
                end
            end
            StGap: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers; reset returns everything to idle at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            rr_ptr_q  <= '0;
            cur_src_q <= '0;
            timer_q   <= '0;
            data_q    <= '0;
            strobe_q  <= 1'b0;
            ack_q     <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            cur_src_q <= cur_src_d;
            timer_q   <= timer_d;
            data_q    <= data_d;
            strobe_q  <= strobe_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.src_ack        = ack_q;
    assign bus.ser_strobe_in  = strobe_q;
    assign bus.ser_input_data = data_q;
    assign bus.busy           = (state_q != StIdle);
    assign bus.cur_src        = cur_src_q;
    assign bus.done           = done_q;
    assign bus.err_timeout    = err_q;
    assign bus.word_cnt       = cnt_q;

endmodule
